// File: rtl/run_light_pkg.sv
// Shared pattern tables for the running-light bus, used by both the generator and the monitor.
package run_light_pkg;

  typedef enum logic [1:0] {
    MODE_FILL     = 2'd0,
    MODE_CONVERGE = 2'd1,
    MODE_SWEEP    = 2'd2,
    MODE_PAIR     = 2'd3
  } mode_e;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  localparam int LEN_FILL     = 16;
  localparam int LEN_CONVERGE = 8;
  localparam int LEN_SWEEP    = 9;
  localparam int LEN_PAIR     = 5;
  localparam int STEP_W       = 4;

  function automatic int mode_len(input mode_e mode);
    case (mode)
      MODE_FILL:     return LEN_FILL;
      MODE_CONVERGE: return LEN_CONVERGE;
      MODE_SWEEP:    return LEN_SWEEP;
      default:       return LEN_PAIR;
    endcase
  endfunction

  function automatic logic [7:0] pattern(input mode_e mode, input logic [STEP_W-1:0] step);
    logic [7:0] p;
    p = 8'h00;
    case (mode)
      MODE_FILL: begin
        case (step)
          4'd0:  p = 8'h80;
          4'd1:  p = 8'hC0;
          4'd2:  p = 8'hE0;
          4'd3:  p = 8'hF0;
          4'd4:  p = 8'hF8;
          4'd5:  p = 8'hFC;
          4'd6:  p = 8'hFE;
          4'd7:  p = 8'hFF;
          4'd8:  p = 8'h7F;
          4'd9:  p = 8'h3F;
          4'd10: p = 8'h1F;
          4'd11: p = 8'h0F;
          4'd12: p = 8'h07;
          4'd13: p = 8'h03;
          4'd14: p = 8'h01;
          default: p = 8'h00;
        endcase
      end
      MODE_CONVERGE: begin
        case (step)
          4'd0: p = 8'h81;
          4'd1: p = 8'hC3;
          4'd2: p = 8'hE7;
          4'd3: p = 8'hFF;
          4'd4: p = 8'h7E;
          4'd5: p = 8'h3C;
          4'd6: p = 8'h18;
          default: p = 8'h00;
        endcase
      end
      MODE_SWEEP: begin
        case (step)
          4'd0: p = 8'hF0;
          4'd1: p = 8'hF1;
          4'd2: p = 8'hF3;
          4'd3: p = 8'hF7;
          4'd4: p = 8'hFF;
          4'd5: p = 8'hEF;
          4'd6: p = 8'hCF;
          4'd7: p = 8'h8F;
          default: p = 8'h0F;
        endcase
      end
      default: begin
        case (step)
          4'd0: p = 8'h03;
          4'd1: p = 8'h0F;
          4'd2: p = 8'h3F;
          4'd3: p = 8'hFF;
          default: p = 8'h00;
        endcase
      end
    endcase
    return p;
  endfunction

endpackage

// File: rtl/rl_mode_tracker.sv
// Follows one running-light mode: step register, match against the table, wrap/done and run length.
module rl_mode_tracker
  import run_light_pkg::*;
#(
  parameter mode_e MODE = MODE_FILL
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_vld,
  input  logic              clear,
  input  logic [7:0]        frame,
  output logic              match,
  output logic              done,
  output logic [STEP_W:0]   run
);

  localparam int LEN = mode_len(MODE);
  localparam logic [STEP_W-1:0] LAST     = STEP_W'(LEN - 1);
  localparam logic [STEP_W:0]   RUN_FULL = (STEP_W+1)'(LEN);

  logic [STEP_W-1:0] step;
  logic [STEP_W-1:0] step_next;
  logic              restart;
  logic              last;

  assign match   = (frame == pattern(MODE, step));
  assign restart = (frame == pattern(MODE, '0));
  assign last    = (step == LAST);
  assign done    = frame_vld && match && last;

  // run is the post-update in-order length; a completed sequence reports the full length
  always_comb begin
    step_next = '0;
    run       = '0;
    if (match) begin
      step_next = last ? '0 : step + STEP_W'(1);
      run       = last ? RUN_FULL : {1'b0, step} + (STEP_W+1)'(1);
    end else if (restart) begin
      step_next = STEP_W'(1);
      run       = (STEP_W+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step <= '0;
    end else if (clear) begin
      step <= '0;
    end else if (frame_vld) begin
      step <= step_next;
    end
  end

endmodule

// File: rtl/run_light_monitor.sv
// Receive-side checker for the running-light bus: identifies the mode, tracks lock, done and errors.
// Optional idle timeout that drops lock is built only when RL_MON_TIMEOUT_EN is defined.
module run_light_monitor
  import run_light_pkg::*;
#(
  parameter int LOCK_LEN    = 2,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       frame,
  input  logic             frame_vld,
  output logic             locked,
  output logic [1:0]       mode_id,
  output logic             seq_done,
  output logic             err,
  output logic [CNT_W-1:0] seq_count
);

  localparam logic [STEP_W:0] LOCK_RUN = (STEP_W+1)'(LOCK_LEN);

  logic [3:0]        trk_match;
  logic [3:0]        trk_done;
  logic [STEP_W:0]   trk_run [4];
  logic              clear_all;
  logic              timeout;

  lock_state_e       state, state_next;
  mode_e             mode_r, mode_next;
  logic              done_next, err_next;
  logic [CNT_W-1:0]  count_next;

  for (genvar m = 0; m < 4; m++) begin : g_trk
    rl_mode_tracker #(.MODE(mode_e'(m))) u_trk (
      .clk       (clk),
      .reset     (reset),
      .frame_vld (frame_vld),
      .clear     (clear_all),
      .frame     (frame),
      .match     (trk_match[m]),
      .done      (trk_done[m]),
      .run       (trk_run[m])
    );
  end

`ifdef RL_MON_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  logic [IDLE_W-1:0] idle_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if (frame_vld) begin
      idle_cnt <= '0;
    end else if (idle_cnt != IDLE_W'(TIMEOUT_CYC)) begin
      idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end

  assign timeout = !frame_vld && (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  assign clear_all = timeout && (state == LOCKED);

  // Descending scan so the lowest-numbered mode wins simultaneous lock hits
  always_comb begin
    state_next = state;
    mode_next  = mode_r;
    done_next  = 1'b0;
    err_next   = 1'b0;
    count_next = seq_count;
    if (clear_all) begin
      state_next = UNLOCKED;
      err_next   = 1'b1;
    end else if (frame_vld) begin
      case (state)
        UNLOCKED: begin
          for (int m = 3; m >= 0; m--) begin
            if (trk_run[m] >= LOCK_RUN) begin
              state_next = LOCKED;
              mode_next  = mode_e'(m);
            end
          end
        end
        default: begin
          if (!trk_match[mode_r]) begin
            err_next   = 1'b1;
            state_next = UNLOCKED;
          end else if (trk_done[mode_r]) begin
            done_next = 1'b1;
            if (seq_count != '1) count_next = seq_count + CNT_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= UNLOCKED;
      mode_r    <= MODE_FILL;
      seq_done  <= 1'b0;
      err       <= 1'b0;
      seq_count <= '0;
    end else begin
      state     <= state_next;
      mode_r    <= mode_next;
      seq_done  <= done_next;
      err       <= err_next;
      seq_count <= count_next;
    end
  end

  assign locked  = (state == LOCKED);
  assign mode_id = mode_r;

endmodule

// File: tb/tb_run_light_monitor.sv
// Directed self-checking bench for run_light_monitor; expectations are hand-computed from the pattern tables.
module tb_run_light_monitor;

  localparam int CNT_W = 8;

  logic             clk;
  logic             reset;
  logic [7:0]       frame;
  logic             frame_vld;
  logic             locked;
  logic [1:0]       mode_id;
  logic             seq_done;
  logic             err;
  logic [CNT_W-1:0] seq_count;

  int total;
  int bad;

  run_light_monitor #(
    .LOCK_LEN    (2),
    .CNT_W       (CNT_W),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .frame     (frame),
    .frame_vld (frame_vld),
    .locked    (locked),
    .mode_id   (mode_id),
    .seq_done  (seq_done),
    .err       (err),
    .seq_count (seq_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag, input logic l, input logic [1:0] m,
                              input logic d, input logic e, input logic [CNT_W-1:0] c);
    check_output({tag, ".locked"},    32'(locked),    32'(l));
    check_output({tag, ".mode_id"},   32'(mode_id),   32'(m));
    check_output({tag, ".seq_done"},  32'(seq_done),  32'(d));
    check_output({tag, ".err"},       32'(err),       32'(e));
    check_output({tag, ".seq_count"}, 32'(seq_count), 32'(c));
  endtask

  // Called at a negedge; drives one valid frame across the next rising edge
  task automatic apply_stimulus(input logic [7:0] f);
    frame     = f;
    frame_vld = 1'b1;
    @(negedge clk);
    frame_vld = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_dut(input string tag);
    reset = 1'b1;
    @(negedge clk);
    check_status({tag, ".in_reset"}, 1'b0, 2'd0, 1'b0, 1'b0, '0);
    reset = 1'b0;
    @(negedge clk);
  endtask

  logic [7:0] fill_tab [16];
  logic [7:0] conv_tab [8];

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    frame = 8'h00;
    frame_vld = 1'b0;
    fill_tab = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF,
                 8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00};
    conv_tab = '{8'h81, 8'hC3, 8'hE7, 8'hFF, 8'h7E, 8'h3C, 8'h18, 8'h00};
    idle_cycles(3);
    check_status("por", 1'b0, 2'd0, 1'b0, 1'b0, '0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] mode 1 full sequence");
    apply_stimulus(conv_tab[0]);
    check_status("m1_f0", 1'b0, 2'd0, 1'b0, 1'b0, 8'd0);
    apply_stimulus(conv_tab[1]);
    check_status("m1_f1", 1'b1, 2'd1, 1'b0, 1'b0, 8'd0);
    for (int i = 2; i < 7; i++) begin
      apply_stimulus(conv_tab[i]);
      check_status($sformatf("m1_f%0d", i), 1'b1, 2'd1, 1'b0, 1'b0, 8'd0);
    end
    apply_stimulus(conv_tab[7]);
    check_status("m1_done", 1'b1, 2'd1, 1'b1, 1'b0, 8'd1);
    idle_cycles(1);
    check_status("m1_pulse_end", 1'b1, 2'd1, 1'b0, 1'b0, 8'd1);

    $display("[TB] mode 0 twice");
    reset_dut("rst_m0");
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 16; i++) begin
        apply_stimulus(fill_tab[i]);
        if (r == 0 && i == 0)
          check_status("m0_first", 1'b0, 2'd0, 1'b0, 1'b0, 8'd0);
        else if (i == 15)
          check_status($sformatf("m0_done%0d", r), 1'b1, 2'd0, 1'b1, 1'b0, CNT_W'(r + 1));
        else
          check_status($sformatf("m0_r%0d_f%0d", r, i), 1'b1, 2'd0, 1'b0, 1'b0, CNT_W'(r));
      end
    end

    $display("[TB] mode 3 break, relock, done then bad restart");
    reset_dut("rst_m3");
    apply_stimulus(8'h03);
    apply_stimulus(8'h0F);
    check_status("m3_lock", 1'b1, 2'd3, 1'b0, 1'b0, 8'd0);
    apply_stimulus(8'h3C);
    check_status("m3_break", 1'b0, 2'd3, 1'b0, 1'b1, 8'd0);
    idle_cycles(1);
    check_status("m3_err_end", 1'b0, 2'd3, 1'b0, 1'b0, 8'd0);
    apply_stimulus(8'h03);
    check_status("m3_re0", 1'b0, 2'd3, 1'b0, 1'b0, 8'd0);
    apply_stimulus(8'h0F);
    check_status("m3_relock", 1'b1, 2'd3, 1'b0, 1'b0, 8'd0);
    apply_stimulus(8'h03);
    check_status("m3_restart_err", 1'b0, 2'd3, 1'b0, 1'b1, 8'd0);
    apply_stimulus(8'h0F);
    check_status("m3_restart_lock", 1'b1, 2'd3, 1'b0, 1'b0, 8'd0);
    apply_stimulus(8'h3F);
    apply_stimulus(8'hFF);
    apply_stimulus(8'h00);
    check_status("m3_done", 1'b1, 2'd3, 1'b1, 1'b0, 8'd1);
    apply_stimulus(8'h0F);
    check_status("m3_bad_next", 1'b0, 2'd3, 1'b0, 1'b1, 8'd1);

    $display("[TB] mode 2 with idle gaps");
    reset_dut("rst_m2gap");
    apply_stimulus(8'hF0);
    idle_cycles(5);
    check_status("m2_gap", 1'b0, 2'd0, 1'b0, 1'b0, 8'd0);
    apply_stimulus(8'hF1);
    check_status("m2_lock", 1'b1, 2'd2, 1'b0, 1'b0, 8'd0);
    idle_cycles(5);
    check_status("m2_hold", 1'b1, 2'd2, 1'b0, 1'b0, 8'd0);
    apply_stimulus(8'hF1);
    check_status("m2_repeat", 1'b0, 2'd2, 1'b0, 1'b1, 8'd0);

    $display("[TB] reset mid-sequence");
    reset_dut("rst_m2mid_pre");
    apply_stimulus(8'hF0);
    apply_stimulus(8'hF1);
    apply_stimulus(8'hF3);
    apply_stimulus(8'hF7);
    apply_stimulus(8'hFF);
    check_status("m2_mid", 1'b1, 2'd2, 1'b0, 1'b0, 8'd0);
    reset_dut("rst_m2mid");
    apply_stimulus(8'hF1);
    check_status("m2_after_rst", 1'b0, 2'd0, 1'b0, 1'b0, 8'd0);
    apply_stimulus(8'hF0);
    apply_stimulus(8'hF1);
    check_status("m2_relock", 1'b1, 2'd2, 1'b0, 1'b0, 8'd0);

    $display("[TB] seq_count saturation");
    reset_dut("rst_sat");
    for (int n = 0; n < 256; n++) begin
      apply_stimulus(8'h03);
      apply_stimulus(8'h0F);
      apply_stimulus(8'h3F);
      apply_stimulus(8'hFF);
      apply_stimulus(8'h00);
      if (n == 254)
        check_status("sat_255", 1'b1, 2'd3, 1'b1, 1'b0, 8'hFF);
    end
    check_status("sat_hold", 1'b1, 2'd3, 1'b1, 1'b0, 8'hFF);

    $display("[TB] idle timeout");
    reset_dut("rst_to");
    apply_stimulus(8'h81);
    apply_stimulus(8'hC3);
    check_status("to_lock", 1'b1, 2'd1, 1'b0, 1'b0, 8'd0);
    idle_cycles(15);
    check_status("to_15", 1'b1, 2'd1, 1'b0, 1'b0, 8'd0);
    idle_cycles(1);
`ifdef RL_MON_TIMEOUT_EN
    check_status("to_16", 1'b0, 2'd1, 1'b0, 1'b1, 8'd0);
    idle_cycles(1);
    check_status("to_17", 1'b0, 2'd1, 1'b0, 1'b0, 8'd0);
`else
    check_status("to_16", 1'b1, 2'd1, 1'b0, 1'b0, 8'd0);
    idle_cycles(40);
    check_status("to_56", 1'b1, 2'd1, 1'b0, 1'b0, 8'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
